// File: rtl/hack_stream_transmitter.sv
// Hack bus peripheral that queues CPU words and replays them over the load/sck/data/ack ROM stream link.
// Optional ack watchdog is built when STREAM_TX_TIMEOUT_EN is defined.
module hack_stream_transmitter #(
  parameter int WORD_WIDTH      = 16,
  parameter int ADDRESS_WIDTH   = 15,
  parameter int DATA_ADDRESS    = 24578,
  parameter int CTRL_ADDRESS    = 24579,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int SETUP_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                     hack_clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] addressM,
  input  logic                     writeM,
  input  logic [WORD_WIDTH-1:0]    outM,
  output logic [WORD_WIDTH-1:0]    read_data,
  output logic                     selected,
  output logic                     stream_load,
  output logic                     stream_sck,
  output logic [WORD_WIDTH-1:0]    stream_data,
  input  logic                     stream_ack
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W   = FIFO_DEPTH_LOG2 + 1;
  localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, OPEN, SETUP, SCK_HIGH, SCK_LOW} state_t;

  state_t                     state, next_state;
  logic                       ack_meta, ack_s;
  logic [WORD_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [SETUP_W-1:0]         setup_cnt;
  logic                       enable, overflow, timeout_flag;
  logic                       data_sel, ctrl_sel, data_wr, ctrl_wr;
  logic                       fifo_full, fifo_empty, push, pop, abort, busy;

  assign data_sel   = (addressM == ADDRESS_WIDTH'(DATA_ADDRESS));
  assign ctrl_sel   = (addressM == ADDRESS_WIDTH'(CTRL_ADDRESS));
  assign selected   = data_sel | ctrl_sel;
  assign data_wr    = writeM & data_sel;
  assign ctrl_wr    = writeM & ctrl_sel;
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = data_wr & (~fifo_full | pop) & ~abort;
  assign busy       = ((state != IDLE) && (state != OPEN)) || !fifo_empty;

`ifdef STREAM_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            in_handshake;

  assign in_handshake = (state == SCK_HIGH) || (state == SCK_LOW);
  // wd_cnt holds cycles spent in the current handshake state minus one
  assign abort = in_handshake && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge hack_clk) begin
    if (reset || next_state != state) wd_cnt <= '0;
    else if (in_handshake && !abort)  wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE:     if (enable) next_state = OPEN;
      OPEN: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = SETUP;
        end else if (!enable) begin
          next_state = IDLE;
        end
      end
      SETUP:    if (setup_cnt == SETUP_W'(SETUP_CYCLES - 1)) next_state = SCK_HIGH;
      SCK_HIGH: if (ack_s)  next_state = SCK_LOW;
      SCK_LOW:  if (!ack_s) next_state = OPEN;
      default:  next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // Control: state, synchronizer, FIFO pointers and CPU-visible flags
  always_ff @(posedge hack_clk) begin
    if (reset) begin
      state        <= IDLE;
      ack_meta     <= 1'b0;
      ack_s        <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      setup_cnt    <= '0;
      enable       <= 1'b0;
      overflow     <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state    <= next_state;
      ack_meta <= stream_ack;
      ack_s    <= ack_meta;
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
      if (pop)                  setup_cnt <= '0;
      else if (state == SETUP)  setup_cnt <= setup_cnt + 1'b1;
      if (ctrl_wr) begin
        enable <= outM[0];
        if (outM[7]) begin
          overflow     <= 1'b0;
          timeout_flag <= 1'b0;
        end
      end
      if (data_wr && !push) overflow <= 1'b1;
      if (abort) begin
        enable       <= 1'b0;
        timeout_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge hack_clk) begin
    if (push) mem[wr_ptr] <= outM;
  end

  // Link outputs follow the state being entered on this edge
  always_ff @(posedge hack_clk) begin
    if (reset) begin
      stream_load <= 1'b0;
      stream_sck  <= 1'b0;
      stream_data <= '0;
    end else begin
      stream_load <= (next_state != IDLE);
      stream_sck  <= (next_state == SCK_HIGH);
      if (pop) stream_data <= mem[rd_ptr];
    end
  end

  always_comb begin
    read_data = '0;
    if (ctrl_sel) begin
      read_data[0]    = enable;
      read_data[1]    = busy;
      read_data[2]    = fifo_full;
      read_data[3]    = fifo_empty;
      read_data[4]    = timeout_flag;
      read_data[5]    = overflow;
      read_data[11:8] = 4'(count);
    end
  end

endmodule

// File: tb/tb_hack_stream_transmitter.sv
// Scoreboard bench for hack_stream_transmitter: CPU pushes feed an expected-word queue, a receiver model acks and checks.
module tb_hack_stream_transmitter;
  localparam int AW     = 15;
  localparam int DATA_A = 24578;
  localparam int CTRL_A = 24579;

  logic          hack_clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addressM;
  logic          writeM;
  logic [15:0]   outM;
  logic [15:0]   read_data;
  logic          selected;
  logic          stream_load, stream_sck, stream_ack;
  logic [15:0]   stream_data;

  int          tests = 0;
  int          fails = 0;
  int          pulses = 0;
  logic [15:0] sb[$];
  bit          rx_auto = 1'b0;
  bit          ack_hold = 1'b0;
  int          ack_dly = 2;
  logic        prev_sck = 1'b0;
  logic [15:0] prev_data = '0;

  hack_stream_transmitter #(.TIMEOUT_CYCLES(8)) dut (
    .hack_clk(hack_clk), .reset(reset), .addressM(addressM), .writeM(writeM), .outM(outM),
    .read_data(read_data), .selected(selected), .stream_load(stream_load),
    .stream_sck(stream_sck), .stream_data(stream_data), .stream_ack(stream_ack)
  );

  always #5 hack_clk = ~hack_clk;

  // Receiver side: each rising sck consumes one expected word
  always @(negedge hack_clk) begin
    if (stream_sck && !prev_sck) begin
      pulses++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: got %h, required no pulse (queue empty)", stream_data);
      end else begin
        logic [15:0] exp_w;
        exp_w = sb.pop_front();
        if (stream_data !== exp_w) begin
          fails++;
          $display("FAIL word_value: got %h, required %h", stream_data, exp_w);
        end
      end
      tests++;
      if (prev_data !== stream_data) begin
        fails++;
        $display("FAIL data_setup: data before sck %h, at sck %h", prev_data, stream_data);
      end
      tests++;
      if (stream_load !== 1'b1) begin
        fails++;
        $display("FAIL load_during_word: got %b, required 1", stream_load);
      end
    end
    prev_sck  = stream_sck;
    prev_data = stream_data;
  end

  initial begin
    int cnt;
    stream_ack = 1'b0;
    cnt = 0;
    forever begin
      @(negedge hack_clk);
      if (ack_hold) begin
        stream_ack = 1'b1;
      end else if (rx_auto) begin
        if (stream_sck != stream_ack) begin
          cnt++;
          if (cnt >= ack_dly) begin
            stream_ack = stream_sck;
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        stream_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic cpu_write(input int a, input logic [15:0] d);
    @(negedge hack_clk);
    addressM = a[AW-1:0];
    writeM   = 1'b1;
    outM     = d;
    @(negedge hack_clk);
    writeM   = 1'b0;
    addressM = '0;
    outM     = '0;
  endtask

  task automatic push_word(input logic [15:0] d);
    sb.push_back(d);
    cpu_write(DATA_A, d);
  endtask

  task automatic cpu_read(output logic [15:0] v);
    addressM = CTRL_A[AW-1:0];
    #1 v = read_data;
    addressM = '0;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (pulses < n && c < budget) begin
      @(negedge hack_clk);
      c++;
    end
    tests++;
    if (pulses < n) begin
      fails++;
      $display("FAIL %s_timeout: pulses %0d, required %0d", name, pulses, n);
    end
  endtask

  task automatic do_reset();
    @(negedge hack_clk);
    reset    = 1'b1;
    rx_auto  = 1'b0;
    ack_hold = 1'b0;
    repeat (2) @(negedge hack_clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    logic [15:0] v;
    do_reset();
    cpu_read(v);
    tests++;
    if (v !== 16'h0008) begin fails++; $display("FAIL reset_status: got %h, required 0008", v); end
    tests++;
    if (stream_load !== 1'b0 || stream_sck !== 1'b0 || stream_data !== 16'h0) begin
      fails++;
      $display("FAIL reset_link: load %b sck %b data %h, required 0 0 0000", stream_load, stream_sck, stream_data);
    end
    addressM = DATA_A[AW-1:0];
    #1;
    tests++;
    if (selected !== 1'b1 || read_data !== 16'h0) begin
      fails++;
      $display("FAIL data_addr_decode: selected %b read %h, required 1 0000", selected, read_data);
    end
    addressM = 15'd100;
    #1;
    tests++;
    if (selected !== 1'b0) begin fails++; $display("FAIL other_addr_decode: got %b, required 0", selected); end
    addressM = '0;
  endtask

  task automatic test_transfer();
    logic [15:0] v;
    int p0;
    p0 = pulses;
    rx_auto = 1'b1;
    ack_dly = 2;
    push_word(16'h1234);
    push_word(16'hABCD);
    cpu_write(CTRL_A, 16'h0001);
    wait_pulses(p0 + 2, 200, "transfer");
    repeat (12) @(negedge hack_clk);
    tests++;
    if (stream_load !== 1'b1) begin fails++; $display("FAIL load_held_while_enabled: got %b, required 1", stream_load); end
    cpu_write(CTRL_A, 16'h0000);
    repeat (4) @(negedge hack_clk);
    tests++;
    if (stream_load !== 1'b0) begin fails++; $display("FAIL load_drop: got %b, required 0", stream_load); end
    cpu_read(v);
    tests++;
    if (v !== 16'h0008) begin fails++; $display("FAIL transfer_status: got %h, required 0008", v); end
    tests++;
    if (pulses !== p0 + 2) begin fails++; $display("FAIL transfer_pulses: got %0d, required %0d", pulses, p0 + 2); end
  endtask

  task automatic test_disable_midword();
    int p0;
    p0 = pulses;
    rx_auto = 1'b1;
    push_word(16'h0A01);
    push_word(16'h0A02);
    push_word(16'h0A03);
    cpu_write(CTRL_A, 16'h0001);
    wait_pulses(p0 + 1, 100, "midword_first");
    cpu_write(CTRL_A, 16'h0000);
    tests++;
    if (stream_load !== 1'b1) begin fails++; $display("FAIL load_after_disable: got %b, required 1", stream_load); end
    wait_pulses(p0 + 3, 200, "midword_drain");
    repeat (12) @(negedge hack_clk);
    tests++;
    if (stream_load !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL midword_end: load %b left %0d, required 0 0", stream_load, sb.size());
    end
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back(16'h5000 + 16'(i));
      cpu_write(DATA_A, 16'h5000 + 16'(i));
    end
    cpu_read(v);
    tests++;
    if (v !== 16'h0426) begin fails++; $display("FAIL overflow_status: got %h, required 0426", v); end
    cpu_write(CTRL_A, 16'h0080);
    cpu_read(v);
    tests++;
    if (v !== 16'h0406) begin fails++; $display("FAIL overflow_clear: got %h, required 0406", v); end
    tests++;
    if (stream_load !== 1'b0) begin fails++; $display("FAIL disabled_load: got %b, required 0", stream_load); end
    do_reset();
    cpu_read(v);
    tests++;
    if (v !== 16'h0008) begin fails++; $display("FAIL reset_flush: got %h, required 0008", v); end
  endtask

  task automatic test_ack_stall();
    logic [15:0] v;
    int p0;
    p0 = pulses;
    ack_hold = 1'b1;
    push_word(16'hC001);
    push_word(16'hC002);
    cpu_write(CTRL_A, 16'h0001);
    wait_pulses(p0 + 1, 100, "stall_first");
    repeat (30) @(negedge hack_clk);
    tests++;
    if (pulses !== p0 + 1 || stream_sck !== 1'b0) begin
      fails++;
      $display("FAIL stall_hold: pulses %0d sck %b, required %0d 0", pulses, stream_sck, p0 + 1);
    end
    cpu_read(v);
    tests++;
    if (v[11:8] !== 4'd1 || v[1] !== 1'b1) begin
      fails++;
      $display("FAIL stall_status: got %h, required count 1 busy 1", v);
    end
    ack_hold = 1'b0;
    rx_auto  = 1'b1;
    wait_pulses(p0 + 2, 100, "stall_release");
    cpu_write(CTRL_A, 16'h0000);
    repeat (12) @(negedge hack_clk);
    cpu_read(v);
    tests++;
    if (v !== 16'h0008) begin fails++; $display("FAIL stall_end_status: got %h, required 0008", v); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    int p0;
    p0 = pulses;
    rx_auto = 1'b0;
    for (int i = 0; i < 4; i++) push_word(16'hD000 + 16'(i));
    cpu_write(CTRL_A, 16'h0001);
    wait_pulses(p0 + 1, 100, "resetmid_first");
    repeat (2) @(negedge hack_clk);
    tests++;
    if (stream_sck !== 1'b1) begin fails++; $display("FAIL resetmid_in_sck_high: got %b, required 1", stream_sck); end
    reset = 1'b1;
    @(negedge hack_clk);
    cpu_read(v);
    tests++;
    if (stream_sck !== 1'b0 || stream_load !== 1'b0 || v !== 16'h0008) begin
      fails++;
      $display("FAIL resetmid_abort: sck %b load %b status %h, required 0 0 0008", stream_sck, stream_load, v);
    end
    @(negedge hack_clk);
    reset = 1'b0;
    sb.delete();
    rx_auto = 1'b1;
    repeat (40) @(negedge hack_clk);
    tests++;
    if (pulses !== p0 + 1 || stream_load !== 1'b0) begin
      fails++;
      $display("FAIL resetmid_quiet: pulses %0d load %b, required %0d 0", pulses, stream_load, p0 + 1);
    end
    cpu_write(CTRL_A, 16'h0001);
    @(negedge hack_clk);
    tests++;
    if (stream_load !== 1'b1) begin fails++; $display("FAIL reenable_load: got %b, required 1", stream_load); end
    push_word(16'hE00E);
    wait_pulses(p0 + 2, 100, "resetmid_new");
    cpu_write(CTRL_A, 16'h0000);
    repeat (12) @(negedge hack_clk);
  endtask

`ifdef STREAM_TX_TIMEOUT_EN
  task automatic test_timeout();
    logic [15:0] v;
    int c;
    int p0;
    p0 = pulses;
    rx_auto = 1'b0;
    push_word(16'hF00F);
    cpu_write(CTRL_A, 16'h0001);
    wait_pulses(p0 + 1, 100, "timeout_first");
    c = 0;
    while (stream_sck === 1'b1 && c < 40) begin
      @(negedge hack_clk);
      c++;
    end
    tests++;
    if (c !== 8) begin fails++; $display("FAIL timeout_cycles: got %0d, required 8", c); end
    cpu_read(v);
    tests++;
    if (stream_load !== 1'b0 || v !== 16'h0018) begin
      fails++;
      $display("FAIL timeout_status: load %b status %h, required 0 0018", stream_load, v);
    end
    cpu_write(CTRL_A, 16'h0080);
    cpu_read(v);
    tests++;
    if (v !== 16'h0008) begin fails++; $display("FAIL timeout_clear: got %h, required 0008", v); end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    addressM = '0;
    writeM   = 1'b0;
    outM     = '0;
    test_reset();
    test_transfer();
    test_disable_midword();
    test_overflow();
    test_ack_stall();
    test_reset_mid();
`ifdef STREAM_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
